// File: rtl/ddr2_test_pkg.sv
// ddr2_test_pkg -- shared definitions for the DDR2 example self-test.
//   test_state_e : test sequencer states (IDLE, WRITE, READ, DRAIN, DONE)
//   LFSR_POLY    : Galois LFSR feedback mask, polynomial 0x80200003
//   DEFAULT_SEED : default LFSR start value (must be nonzero)
//   lfsr_next()  : one right-shifting Galois LFSR step
package ddr2_test_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } test_state_e;

  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_0001;

  // Right-shift Galois form: the bit shifted out of bit 0 selects the
  // feedback mask. Bit 31 of the mask is set, so a nonzero state never
  // collapses to zero.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    logic [31:0] shifted;
    shifted = s >> 1;
    return s[0] ? (shifted ^ LFSR_POLY) : shifted;
  endfunction

endpackage

// File: rtl/ddr2_test_lfsr.sv
// ddr2_test_lfsr -- 32-bit Galois LFSR used as pattern generator/checker.
//   clk     : clock, state updates on rising edge
//   reset_n : synchronous active-high reset (loads SEED)
//   load    : reload SEED (takes priority over enable)
//   enable  : advance one LFSR step
//   state   : current 32-bit LFSR value
module ddr2_test_lfsr
  import ddr2_test_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        enable,
  output logic [31:0] state
);

  always_ff @(posedge clk) begin
    if (reset_n || load) begin
      state <= SEED;
    end else if (enable) begin
      state <= lfsr_next(state);
    end
  end

endmodule

// File: rtl/ddr2_ctrl_test_example_sim_e0_d0.sv
// ddr2_ctrl_test_example_sim_e0_d0 -- memory self-test: writes an LFSR
// pattern over every word of a behavioural memory model, reads it back
// through a fixed-latency read pipeline and checks it against a second
// LFSR started from the same seed.
//
// Ports:
//   clk          : sole clock
//   reset_n      : synchronous reset, ACTIVE-HIGH despite the name
//   clkby2       : reserved, has no effect
//   test_complete: high while the sequencer is in DONE
//   pnf          : sticky pass flag, cleared by the first mismatching word
//   pnf_per_byte : sticky per-byte pass flags (bit i <-> data[8i+7:8i])
//   err_count    : mismatching words seen, saturates at 16'hFFFF
//   fsm_state    : current sequencer state (debug visibility)
//
// Build option: define DDR2_TEST_LOOP_EN to make DONE a one-cycle state that
// restarts the test from IDLE; error flags and count carry across passes.
//
// Handshake: there is none externally; internally every read issued in READ
// pushes a valid bit into an RD_LAT-deep pipeline, and each valid bit that
// emerges while in READ or DRAIN produces exactly one compare.
module ddr2_ctrl_test_example_sim_e0_d0
  import ddr2_test_pkg::*;
#(
  parameter int          ADDR_W = 8,
  parameter int          RD_LAT = 4,
  parameter logic [31:0] SEED   = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clkby2,
  output logic        test_complete,
  output logic        pnf,
  output logic [3:0]  pnf_per_byte,
  output logic [15:0] err_count,
  output test_state_e fsm_state
);

  localparam int DEPTH = 1 << ADDR_W;

  test_state_e       state_q;
  test_state_e       state_d;
  logic [ADDR_W-1:0] addr;
  logic [3:0]        drain_cnt;
  logic              addr_last;
  logic              drain_last;

  logic              wr_en;
  logic              rd_en;
  logic              lfsr_load;
  logic              cmp_window;

  logic [31:0]       wr_word;
  logic [31:0]       exp_word;
  logic [31:0]       mem [DEPTH];

  logic [RD_LAT-1:0] pipe_valid;
  logic [31:0]       pipe_data [RD_LAT];
  logic              rd_valid;
  logic [31:0]       rd_word;
  logic [3:0]        byte_diff;
  logic              mismatch;

  // Reserved input: deliberately sunk so it cannot influence anything.
  logic              unused_clkby2;
  assign unused_clkby2 = clkby2;

  assign addr_last  = &addr;
  assign drain_last = (drain_cnt == 4'(RD_LAT - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  state_d = WRITE;
      WRITE: if (addr_last) state_d = READ;
      READ:  if (addr_last) state_d = DRAIN;
      DRAIN: if (drain_last) state_d = DONE;
`ifdef DDR2_TEST_LOOP_EN
      DONE:  state_d = IDLE;
`else
      DONE:  state_d = DONE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    lfsr_load     = 1'b0;
    cmp_window    = 1'b0;
    test_complete = 1'b0;
    case (state_q)
      IDLE:  lfsr_load = 1'b1;
      WRITE: wr_en = 1'b1;
      READ:  begin rd_en = 1'b1; cmp_window = 1'b1; end
      DRAIN: cmp_window = 1'b1;
      DONE:  test_complete = 1'b1;
      default: ;
    endcase
  end

  assign fsm_state = state_q;

  // Address and drain counters. The address wraps naturally from the last
  // word back to 0, which is exactly the start address of the next phase.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      addr      <= '0;
      drain_cnt <= '0;
    end else begin
      if (wr_en || rd_en) begin
        addr <= addr + 1'b1;
      end else begin
        addr <= '0;
      end
      if (state_q == DRAIN) begin
        drain_cnt <= drain_cnt + 4'd1;
      end else begin
        drain_cnt <= '0;
      end
    end
  end

  ddr2_test_lfsr #(.SEED(SEED)) u_wr_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .enable  (wr_en),
    .state   (wr_word)
  );

  ddr2_test_lfsr #(.SEED(SEED)) u_exp_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (lfsr_load),
    .enable  (rd_valid),
    .state   (exp_word)
  );

  // Memory model; contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_word;
    end
  end

  // Read pipeline: stage 0 is the memory's registered read, so a read issued
  // in cycle r emerges from the last stage in cycle r + RD_LAT.
  always_ff @(posedge clk) begin
    pipe_data[0] <= mem[addr];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  assign rd_valid = pipe_valid[RD_LAT-1] && cmp_window;
  assign rd_word  = pipe_data[RD_LAT-1];

  always_comb begin
    byte_diff = '0;
    for (int i = 0; i < 4; i++) begin
      byte_diff[i] = (rd_word[8*i +: 8] != exp_word[8*i +: 8]);
    end
  end

  assign mismatch = rd_valid && (|byte_diff);

  // Sticky result flags; only reset clears them (a loop restart keeps them).
  always_ff @(posedge clk) begin
    if (reset_n) begin
      pnf          <= 1'b1;
      pnf_per_byte <= 4'hF;
      err_count    <= '0;
    end else if (mismatch) begin
      pnf          <= 1'b0;
      pnf_per_byte <= pnf_per_byte & ~byte_diff;
      if (err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_ddr2_ctrl_test_example_sim_e0_d0.sv
// Directed bench for ddr2_ctrl_test_example_sim_e0_d0: a default-parameter
// instance (ADDR_W=8, RD_LAT=4) and a small instance (ADDR_W=4, RD_LAT=1).
// Cycle k counts rising edges after the negedge at which reset_n drops low.
// Build option DDR2_TEST_LOOP_EN switches the DONE-phase expectations.
module tb_ddr2_ctrl_test_example_sim_e0_d0;
  import ddr2_test_pkg::*;

  logic        clk;
  logic        clkby2;
  logic        reset_n;
  logic        reset_s;

  logic        test_complete;
  logic        pnf;
  logic [3:0]  pnf_per_byte;
  logic [15:0] err_count;
  test_state_e fsm_state;

  logic        s_test_complete;
  logic        s_pnf;
  logic [3:0]  s_pnf_per_byte;
  logic [15:0] s_err_count;
  test_state_e s_fsm_state;

  int checks = 0;
  int errors = 0;

  ddr2_ctrl_test_example_sim_e0_d0 dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .clkby2        (clkby2),
    .test_complete (test_complete),
    .pnf           (pnf),
    .pnf_per_byte  (pnf_per_byte),
    .err_count     (err_count),
    .fsm_state     (fsm_state)
  );

  ddr2_ctrl_test_example_sim_e0_d0 #(.ADDR_W(4), .RD_LAT(1)) dut_small (
    .clk           (clk),
    .reset_n       (reset_s),
    .clkby2        (clkby2),
    .test_complete (s_test_complete),
    .pnf           (s_pnf),
    .pnf_per_byte  (s_pnf_per_byte),
    .err_count     (s_err_count),
    .fsm_state     (s_fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reserved input wiggled at random; results must not change.
  initial clkby2 = 1'b0;
  always @(negedge clk) clkby2 = 1'($urandom_range(1, 0));

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold reset for two edges, check the cleared flags, then release at a
  // negedge so the next rising edge is cycle 1.
  task automatic start_run(input string tag);
    reset_n = 1'b1;
    cycles(2);
    check({tag, "_rst_err"}, 32'(err_count), 32'd0);
    check({tag, "_rst_pnf"}, 32'(pnf), 32'd1);
    reset_n = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset_n = 1'b1;
    reset_s = 1'b1;
    cycles(5);

    // Reset state
    check("rst_tc",    32'(test_complete), 32'd0);
    check("rst_pnf",   32'(pnf),           32'd1);
    check("rst_ppb",   32'(pnf_per_byte),  32'hF);
    check("rst_err",   32'(err_count),     32'd0);
    check("rst_state", 32'(fsm_state),     32'(IDLE));
    check("s_rst_tc",  32'(s_test_complete), 32'd0);

    // Run A: clean pass, both instances released together
    reset_n = 1'b0;
    reset_s = 1'b0;
    cycles(33);
    check("s_tc_33",  32'(s_test_complete), 32'd0);
    cycles(1);
    check("s_tc_34",  32'(s_test_complete), 32'd1);
    check("s_pnf",    32'(s_pnf),           32'd1);
    check("s_ppb",    32'(s_pnf_per_byte),  32'hF);
    check("s_err",    32'(s_err_count),     32'd0);
    cycles(516 - 34);
    check("a_tc_516",    32'(test_complete), 32'd0);
    check("a_state_516", 32'(fsm_state),     32'(DRAIN));
    cycles(1);
    check("a_tc_517",    32'(test_complete), 32'd1);
    check("a_state_517", 32'(fsm_state),     32'(DONE));
    check("a_pnf",       32'(pnf),           32'd1);
    check("a_ppb",       32'(pnf_per_byte),  32'hF);
    check("a_err",       32'(err_count),     32'd0);
`ifdef DDR2_TEST_LOOP_EN
    // DONE lasts one cycle, then IDLE + 256 + 256 + 4 cycles to the next DONE
    cycles(1);
    check("a_loop_tc_518", 32'(test_complete), 32'd0);
    check("a_loop_st_518", 32'(fsm_state),     32'(IDLE));
    cycles(516);
    check("a_loop_tc_1034", 32'(test_complete), 32'd0);
    cycles(1);
    check("a_loop_tc_1035", 32'(test_complete), 32'd1);
    check("a_loop_pnf",     32'(pnf),           32'd1);
`else
    cycles(5);
    check("a_hold_tc",    32'(test_complete),   32'd1);
    check("a_hold_state", 32'(fsm_state),       32'(DONE));
    check("s_hold_tc",    32'(s_test_complete), 32'd1);
`endif

    // Run B: flip bit 3 of word 5 after WRITE finishes (READ starts at 257)
    start_run("b");
    cycles(258);
    dut.mem[5] = dut.mem[5] ^ 32'h0000_0008;
    cycles(517 - 258);
    check("b_tc",  32'(test_complete), 32'd1);
    check("b_err", 32'(err_count),     32'd1);
    check("b_pnf", 32'(pnf),           32'd0);
    check("b_ppb", 32'(pnf_per_byte),  32'hE);
`ifdef DDR2_TEST_LOOP_EN
    // Next pass: READ starts at 518+257; re-inject and expect accumulation
    cycles(259);
    dut.mem[5] = dut.mem[5] ^ 32'h0000_0008;
    cycles(259);
    check("b_loop_tc",  32'(test_complete), 32'd1);
    check("b_loop_err", 32'(err_count),     32'd2);
`endif

    // Run C: corrupt bytes 1 and 3 of words 10 and 11
    start_run("c");
    cycles(258);
    dut.mem[10] = dut.mem[10] ^ 32'hFF00_FF00;
    dut.mem[11] = dut.mem[11] ^ 32'hFF00_FF00;
    cycles(517 - 258);
    check("c_tc",  32'(test_complete), 32'd1);
    check("c_err", 32'(err_count),     32'd2);
    check("c_pnf", 32'(pnf),           32'd0);
    check("c_ppb", 32'(pnf_per_byte),  32'h5);

    // Run D: one-cycle reset pulse at cycle 300 restarts the test
    start_run("d");
    cycles(300);
    reset_n = 1'b1;
    cycles(1);
    check("d_abort_state", 32'(fsm_state),     32'(IDLE));
    check("d_abort_tc",    32'(test_complete), 32'd0);
    reset_n = 1'b0;
    cycles(516);
    check("d_tc_516", 32'(test_complete), 32'd0);
    cycles(1);
    check("d_tc_517", 32'(test_complete), 32'd1);
    check("d_pnf",    32'(pnf),           32'd1);
    check("d_ppb",    32'(pnf_per_byte),  32'hF);
    check("d_err",    32'(err_count),     32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
